// File: rtl/fb_pkg.sv
// Shared framebuffer types and helpers: fetch FSM state encoding and the
// address-width function used to size framebuffer address ports.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic int fb_addr_w(input int width, input int height);
    return (width * height > 1) ? $clog2(width * height) : 1;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register delay line with asynchronous reset and a synchronous
// flush, used to align the address-valid strobe with framebuffer read data.
module pipe_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] vld_p [DEPTH];

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      for (int i = 0; i < DEPTH; i++) vld_p[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) vld_p[i] <= '0;
    end else begin
      vld_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  assign dout = vld_p[DEPTH-1];

endmodule

// File: rtl/fb_line_fetch.sv
// Copies one framebuffer row into the linebuffer at the start of every
// SCALE-th active display line, so each stored row is shown SCALE times.
module fb_line_fetch
  import fb_pkg::*;
#(
  parameter int CORDW     = 16,
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int SCALE     = 4,
  parameter int DATAW     = 4,
  parameter int BRAM_LAT  = 1
) (
  input  logic                                       clk_pix,
  input  logic                                       rst_pix,
  input  logic signed [CORDW-1:0]                    sy,
  input  logic                                       frame,
  input  logic                                       line,
  output logic [fb_addr_w(FB_WIDTH, FB_HEIGHT)-1:0]  fb_addr,
  input  logic [DATAW-1:0]                           fb_data,
  output logic                                       lb_en_in,
  output logic [DATAW-1:0]                           lb_data,
  output logic                                       busy,
  output logic                                       err_overrun
);

  localparam int ADDRW = fb_addr_w(FB_WIDTH, FB_HEIGHT);
  localparam int XW    = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int RW    = $clog2(FB_HEIGHT + 1);
  localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int DW    = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;

  localparam logic signed [CORDW-1:0] SY_END   = CORDW'(FB_HEIGHT * SCALE);
  localparam logic [XW-1:0]           X_LAST   = XW'(FB_WIDTH - 1);
  localparam logic [SW-1:0]           S_LAST   = SW'(SCALE - 1);
  localparam logic [RW-1:0]           ROW_END  = RW'(FB_HEIGHT);
  localparam logic [ADDRW-1:0]        ROW_STEP = ADDRW'(FB_WIDTH);
  localparam logic [DW-1:0]           D_LAST   = DW'(BRAM_LAT - 1);

  fetch_state_t     state, state_nxt;
  logic [XW-1:0]    x_cnt;
  logic [RW-1:0]    row;
  logic [SW-1:0]    scale;
  logic [ADDRW-1:0] row_base;
  logic [DW-1:0]    drain_cnt;

  logic sy_in_range;
  logic fetch_req;
  logic last_x;
  logic drain_done;
  logic addr_vld;

  assign sy_in_range = !sy[CORDW-1] && (sy < SY_END);
  // Rows past the bottom of the framebuffer are never requested.
  assign fetch_req   = line && !frame && sy_in_range && (scale == '0) && (row < ROW_END);
  assign last_x      = (x_cnt == X_LAST);
  assign drain_done  = (drain_cnt == D_LAST);

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    addr_vld  = 1'b0;
    if (frame) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (fetch_req)  state_nxt = FETCH;
        FETCH:   if (last_x)     state_nxt = DRAIN;
        DRAIN:   if (drain_done) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    case (state)
      FETCH: begin
        busy     = 1'b1;
        addr_vld = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Address generation, row/scale bookkeeping and overrun flag
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      fb_addr     <= '0;
      x_cnt       <= '0;
      row         <= '0;
      row_base    <= '0;
      scale       <= '0;
      drain_cnt   <= '0;
      err_overrun <= 1'b0;
    end else if (frame) begin
      fb_addr   <= '0;
      x_cnt     <= '0;
      row       <= '0;
      row_base  <= '0;
      scale     <= '0;
      drain_cnt <= '0;
    end else begin
      if (line && sy_in_range) scale <= (scale == S_LAST) ? '0 : scale + SW'(1);
      if (fetch_req && busy)   err_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (fetch_req) begin
            fb_addr <= row_base;
            x_cnt   <= '0;
          end
        end
        FETCH: begin
          if (last_x) begin
            row       <= row + RW'(1);
            row_base  <= row_base + ROW_STEP;
            drain_cnt <= '0;
          end else begin
            fb_addr <= fb_addr + ADDRW'(1);
            x_cnt   <= x_cnt + XW'(1);
          end
        end
        DRAIN:   drain_cnt <= drain_cnt + DW'(1);
        default: ;
      endcase
    end
  end

  // Valid delay matching the framebuffer read latency
  pipe_delay #(
    .DEPTH (BRAM_LAT),
    .WIDTH (1)
  ) u_vld_pipe (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .clr     (frame),
    .din     (addr_vld),
    .dout    (lb_en_in)
  );

  assign lb_data = fb_data;

endmodule

// File: tb/tb_fb_line_fetch.sv
// Directed bench for fb_line_fetch: default build, a SCALE=1 build for overrun
// and a BRAM_LAT=3 build for latency, all driven from one stimulus stream.
module tb_fb_line_fetch;

  logic               clk = 1'b0;
  logic               rst_pix;
  logic signed [15:0] sy;
  logic               frame, line;

  logic [14:0] addr_a, addr_b, addr_c;
  logic [3:0]  data_a, data_b, data_c;
  logic [3:0]  ldat_a, ldat_b, ldat_c;
  logic        en_a, en_b, en_c;
  logic        busy_a, busy_b, busy_c;
  logic        err_a, err_b, err_c;
  logic [3:0]  rd_c1, rd_c2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ena_cnt = 0, enb_cnt = 0, enc_cnt = 0;
  int starts_a = 0, start_addr_a = 0, max_a = 0;
  int first_c = -1, last_c = -1;
  logic [3:0] first_dat_c = '0;
  logic pb_a = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [3:0] pix(input logic [14:0] a);
    return a[3:0] ^ 4'h5;
  endfunction

  always @(posedge clk) begin
    data_a <= pix(addr_a);
    data_b <= pix(addr_b);
    rd_c1  <= pix(addr_c);
    rd_c2  <= rd_c1;
    data_c <= rd_c2;
  end

  fb_line_fetch u_a (
    .clk_pix(clk), .rst_pix(rst_pix), .sy(sy), .frame(frame), .line(line),
    .fb_addr(addr_a), .fb_data(data_a), .lb_en_in(en_a), .lb_data(ldat_a),
    .busy(busy_a), .err_overrun(err_a)
  );

  fb_line_fetch #(.SCALE(1)) u_b (
    .clk_pix(clk), .rst_pix(rst_pix), .sy(sy), .frame(frame), .line(line),
    .fb_addr(addr_b), .fb_data(data_b), .lb_en_in(en_b), .lb_data(ldat_b),
    .busy(busy_b), .err_overrun(err_b)
  );

  fb_line_fetch #(.BRAM_LAT(3)) u_c (
    .clk_pix(clk), .rst_pix(rst_pix), .sy(sy), .frame(frame), .line(line),
    .fb_addr(addr_c), .fb_data(data_c), .lb_en_in(en_c), .lb_data(ldat_c),
    .busy(busy_c), .err_overrun(err_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (en_a) ena_cnt++;
    if (en_b) enb_cnt++;
    if (en_c) begin
      enc_cnt++;
      if (first_c < 0) begin
        first_c     = cyc;
        first_dat_c = ldat_c;
      end
      last_c = cyc;
    end
    if (busy_a && !pb_a) begin
      starts_a++;
      start_addr_a = int'(addr_a);
    end
    pb_a = busy_a;
    if (int'(addr_a) > max_a) max_a = int'(addr_a);
  endtask

  task automatic strobe_line(input int s);
    sy   = 16'(s);
    line = 1'b1;
    tick();
    line = 1'b0;
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  initial begin
    int n, e0, first, last;
    rst_pix = 1'b1;
    sy      = '0;
    frame   = 1'b0;
    line    = 1'b0;
    tick();
    tick();
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_en",   32'(en_a),   32'd0);
    chk("rst_err",  32'(err_a),  32'd0);
    rst_pix = 1'b0;
    tick();

    // single row
    pulse_frame();
    strobe_line(0);
    for (int c = 1; c <= 162; c++) begin
      chk("row_addr", 32'(addr_a), (c <= 160) ? 32'(c - 1) : 32'd159);
      chk("row_en",   32'(en_a),   32'((c >= 2) && (c <= 161)));
      chk("row_busy", 32'(busy_a), 32'(c <= 161));
      if (c >= 2 && c <= 161) chk("row_data", 32'(ldat_a), 32'(pix(15'(c - 2))));
      tick();
    end

    // vertical scaling
    pulse_frame();
    for (int s = 0; s < 8; s++) begin
      e0 = ena_cnt;
      strobe_line(s);
      first = int'(addr_a);
      repeat (159) tick();
      last = int'(addr_a);
      repeat (40) tick();
      chk("scale_en_cnt", 32'(ena_cnt - e0), (s == 0 || s == 4) ? 32'd160 : 32'd0);
      if (s == 0 || s == 4) begin
        chk("scale_first", 32'(first), 32'((s / 4) * 160));
        chk("scale_last",  32'(last),  32'((s / 4) * 160 + 159));
      end
    end

    // full frame
    pulse_frame();
    ena_cnt  = 0;
    starts_a = 0;
    max_a    = 0;
    e0       = 0;
    for (int s = 0; s < 525; s++) begin
      if (s == 480) e0 = ena_cnt;
      strobe_line(s);
      repeat (44) tick();
    end
    chk("frame_en_total", 32'(ena_cnt), 32'd19200);
    chk("frame_blank_en", 32'(ena_cnt - e0), 32'd0);
    chk("frame_fetches", 32'(starts_a), 32'd120);
    chk("frame_last_start", 32'(start_addr_a), 32'd19040);
    chk("frame_last_addr", 32'(addr_a), 32'd19199);
    chk("frame_max_addr", 32'(max_a), 32'd19199);
    chk("frame_no_overrun", 32'(err_a), 32'd0);

    // no fetch past the last row without a new frame
    e0 = ena_cnt;
    strobe_line(0);
    chk("past_end_busy", 32'(busy_a), 32'd0);
    repeat (199) tick();
    chk("past_end_en", 32'(ena_cnt - e0), 32'd0);
    chk("past_end_addr", 32'(addr_a), 32'd19199);

    // overrun (SCALE=1 build)
    rst_pix = 1'b1;
    tick();
    rst_pix = 1'b0;
    chk("ovr_err_clear", 32'(err_b), 32'd0);
    e0 = enb_cnt;
    strobe_line(0);
    repeat (49) tick();
    strobe_line(1);
    chk("ovr_err_set", 32'(err_b), 32'd1);
    chk("ovr_busy", 32'(busy_b), 32'd1);
    chk("ovr_addr_continues", 32'(addr_b), 32'd50);
    chk("ovr_data", 32'(ldat_b), 32'(pix(15'd49)));
    repeat (200) tick();
    chk("ovr_en_cnt", 32'(enb_cnt - e0), 32'd160);
    chk("ovr_done", 32'(busy_b), 32'd0);
    pulse_frame();
    chk("ovr_err_sticky", 32'(err_b), 32'd1);

    // frame abort mid-fetch
    strobe_line(0);
    repeat (80) tick();
    chk("abort_addr_before", 32'(addr_a), 32'd80);
    chk("abort_en_before", 32'(en_a), 32'd1);
    pulse_frame();
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_addr", 32'(addr_a), 32'd0);
    chk("abort_en", 32'(en_a), 32'd0);
    e0 = ena_cnt;
    repeat (100) tick();
    chk("abort_no_en", 32'(ena_cnt - e0), 32'd0);
    strobe_line(0);
    chk("abort_restart_addr", 32'(addr_a), 32'd0);
    chk("abort_restart_busy", 32'(busy_a), 32'd1);
    tick();
    chk("abort_restart_next", 32'(addr_a), 32'd1);
    repeat (170) tick();

    // asynchronous reset mid-fetch
    pulse_frame();
    strobe_line(0);
    repeat (40) tick();
    #2;
    rst_pix = 1'b1;
    #1;
    chk("arst_addr_c", 32'(addr_c), 32'd0);
    chk("arst_en_c", 32'(en_c), 32'd0);
    chk("arst_busy_c", 32'(busy_c), 32'd0);
    chk("arst_addr_a", 32'(addr_a), 32'd0);
    chk("arst_err_b", 32'(err_b), 32'd0);
    tick();
    tick();
    rst_pix = 1'b0;
    e0 = enc_cnt;
    repeat (200) tick();
    chk("arst_no_en", 32'(enc_cnt - e0), 32'd0);

    // BRAM_LAT=3 rerun straight after reset release, no frame strobe
    first_c = -1;
    last_c  = -1;
    e0      = enc_cnt;
    n       = cyc;
    strobe_line(0);
    repeat (200) tick();
    chk("lat3_first_en", 32'(first_c), 32'(n + 4));
    chk("lat3_last_en", 32'(last_c), 32'(n + 163));
    chk("lat3_en_cnt", 32'(enc_cnt - e0), 32'd160);
    chk("lat3_first_data", 32'(first_dat_c), 32'(pix(15'd0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_line_fetch.md
FB_LINE_FETCH -- requirements
Module: fb_line_fetch

Interface
REQ-001 SHALL have parameter CORDW, default 16, signed display coordinate width (bits).
REQ-002 SHALL have parameter FB_WIDTH, default 160, framebuffer width (pixels).
REQ-003 SHALL have parameter FB_HEIGHT, default 120, framebuffer height (lines).
REQ-004 SHALL have parameter SCALE, default 4, vertical repeat factor (display lines per framebuffer row).
REQ-005 SHALL have parameter DATAW, default 4, colour index width (bits).
REQ-006 SHALL have parameter BRAM_LAT, default 1, framebuffer read latency (cycles, 1..3).
REQ-007 SHALL have port clk_pix, input, 1, pixel clock; this block uses only this one clock.
REQ-008 SHALL have port rst_pix, input, 1, reset: asynchronous, active-high.
REQ-009 SHALL have port sy, input, CORDW signed, current display line.
REQ-010 SHALL have port frame, input, 1, start-of-frame strobe.
REQ-011 SHALL have port line, input, 1, start-of-line strobe.
REQ-012 SHALL have port fb_addr, output, $clog2(FB_WIDTH*FB_HEIGHT), framebuffer read address.
REQ-013 SHALL have port fb_data, input, DATAW, framebuffer read data.
REQ-014 SHALL have port lb_en_in, output, 1, linebuffer write enable.
REQ-015 SHALL have port lb_data, output, DATAW, linebuffer write data.
REQ-016 SHALL have port busy, output, 1, high while a row fetch or drain is in progress.
REQ-017 SHALL have port err_overrun, output, 1, sticky flag: a fetch request arrived while busy.

Function
REQ-018 SHALL have three states: IDLE, FETCH, DRAIN.
REQ-019 SHALL hold a row counter (0..FB_HEIGHT) and a scale counter (0..SCALE-1).
REQ-020 SHALL hold a row base address equal to row counter × FB_WIDTH.
REQ-021 SHALL raise a fetch request when line=1 in cycle N, sy is in [0, FB_HEIGHT*SCALE), scale counter==0 and frame=0.
REQ-022 SHALL, on each line=1 with sy in range, advance the scale counter by 1, wrapping from SCALE-1 to 0.
REQ-023 SHALL leave the scale counter unchanged on line=1 with sy out of range.
REQ-024 SHALL, on a fetch request in IDLE, enter FETCH and drive fb_addr = row base + x in cycles N+1..N+FB_WIDTH for x = 0..FB_WIDTH-1, one address per cycle.
REQ-025 SHALL, after the last address is issued, enter DRAIN for BRAM_LAT cycles, then return to IDLE.
REQ-026 SHALL increment the row counter by 1 on each FETCH-to-DRAIN transition.
REQ-027 SHALL assert lb_en_in in exactly cycles N+1+BRAM_LAT..N+FB_WIDTH+BRAM_LAT.
REQ-028 SHALL drive lb_en_in from a BRAM_LAT-deep registered valid pipeline.
REQ-029 SHALL drive lb_data = fb_data combinationally.
REQ-030 SHALL assert busy in FETCH and DRAIN only.
REQ-031 SHALL, on a fetch request while busy, ignore the request, set err_overrun, and let the current fetch run to completion.
REQ-032 SHALL, on frame=1, return to IDLE from any state in the next cycle, clear the valid pipeline, zero the row and scale counters, and set fb_addr=0.
REQ-033 SHALL give frame priority over a simultaneous line.
REQ-034 SHALL leave err_overrun unchanged on frame.
REQ-035 SHALL hold fb_addr at its last value while in IDLE.
REQ-036 SHALL NOT issue any fetch once the row counter reaches FB_HEIGHT, until the next frame.
REQ-037 SHALL issue no address beyond FB_WIDTH*FB_HEIGHT-1.

Reset
REQ-038 SHALL, while rst_pix=1, force state=IDLE, fb_addr=0, row=0, scale=0, valid pipeline=0, lb_en_in=0, busy=0, err_overrun=0, independent of the clock.
REQ-039 SHALL abandon a fetch in progress on reset with no further lb_en_in pulses.
REQ-040 SHALL respond to the first line strobe after reset release as if at frame start.

Structure
REQ-041 SHALL take its state enum typedef (IDLE/FETCH/DRAIN) from shared package fb_pkg.
REQ-042 SHALL take its address-width helper constant from fb_pkg.
REQ-043 SHALL implement the BRAM_LAT-deep valid pipeline as sub-module pipe_delay, parameterised for depth and width, with asynchronous reset.

Verification
REQ-044 SHALL cover single row: reset, frame, then line with sy=0 at cycle N -> fb_addr 0..159 in N+1..N+160, lb_en_in high N+2..N+161 (BRAM_LAT=1), busy low at N+162.
REQ-045 SHALL cover scaling: line strobes at sy=0..7 -> fetches only at sy=0 (addr 0..159) and sy=4 (addr 160..319).
REQ-046 SHALL cover full frame: 480 active lines -> 120 fetches, last addresses 19040..19199; lines with sy=480..524 produce no lb_en_in.
REQ-047 SHALL cover overrun: FB_WIDTH=160, SCALE=1, second line strobe 50 cycles after the first -> second request ignored, err_overrun=1, first row completes with 160 enables.
REQ-048 SHALL cover frame abort: frame asserted mid-FETCH at x=80 -> next cycle state IDLE, lb_en_in low after the pipeline flush, next sy=0 fetch starts at addr 0.
REQ-049 SHALL cover async reset: rst_pix pulsed between clock edges mid-FETCH -> outputs zero immediately, no further lb_en_in; BRAM_LAT=3 rerun gives lb_en_in at N+4..N+163.
